i2c_target: RTL and testbench

- 7-bit-address I2C target (slave): the far end of the bus driven by I2C_controller.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches its own address, ACKs it, then either delivers written bytes to the fabric or serializes fabric-supplied bytes onto SDA for master reads.
- Drives SDA open-drain only: pull low or release.

---
 rtl/i2c_pkg.sv | 19 +
 rtl/i2c_line_sync.sv | 36 +++
 rtl/i2c_target.sv | 201 ++++++++++++++++++++
 tb/tb_i2c_target.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding and bus-level constants.
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ADDR      = 3'd1,
      ST_ADDR_ACK  = 3'd2,
      ST_WRITE     = 3'd3,
      ST_WRITE_ACK = 3'd4,
      ST_READ      = 3'd5,
      ST_READ_ACK  = 3'd6,
      ST_WAIT_STOP = 3'd7
   } i2c_state_e;

   localparam logic       I2C_ACK          = 1'b0;
   localparam logic       I2C_NACK         = 1'b1;
   localparam logic [6:0] I2C_GENCALL_ADDR = 7'h00;

endpackage

// File: rtl/i2c_line_sync.sv
// One bus line: SYNC_STAGES-flop synchronizer, history flop, and rise/fall detect.
module i2c_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic line_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   hist_q, hist_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], line_in};
      hist_d = sync_q[SYNC_STAGES-1];
   end

   // Reset to the idle-high bus level so leaving reset creates no phantom edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '1;
         hist_q <= 1'b1;
      end else begin
         sync_q <= sync_d;
         hist_q <= hist_d;
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~hist_q;
   assign fall  = ~level & hist_q;

endmodule

// File: rtl/i2c_target.sv
// 7-bit address I2C target. Define I2C_TARGET_GENCALL_EN to also accept general-call writes.
module i2c_target
   import i2c_pkg::*;
#(
   parameter logic [6:0] TARGET_ADDR = 7'h47,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_req,
   output logic       busy,
   output logic       rw,
   output logic [2:0] state_o
);

`ifdef I2C_TARGET_GENCALL_EN
   localparam bit GC_EN = 1'b1;
`else
   localparam bit GC_EN = 1'b0;
`endif

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
      .clk(clk), .reset(reset), .line_in(scl_in),
      .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
   );
   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
      .clk(clk), .reset(reset), .line_in(sda_in),
      .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
   );

   i2c_state_e state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] shift_q, shift_d, rx_data_q, rx_data_d;
   logic       ack_ph_q, ack_ph_d, sda_oe_q, sda_oe_d, busy_q, busy_d;
   logic       rw_q, rw_d, rx_valid_q, rx_valid_d, tx_req_q, tx_req_d;
   logic       start_ev, stop_ev, addr_hit;

   // An SDA edge coinciding with an SCL edge is data, never a START/STOP.
   assign start_ev = sda_fall & scl_lvl & ~scl_rise & ~scl_fall;
   assign stop_ev  = sda_rise & scl_lvl & ~scl_rise & ~scl_fall;
   assign addr_hit = (shift_q[6:0] == TARGET_ADDR) |
                     (GC_EN & (shift_q[6:0] == I2C_GENCALL_ADDR) & (sda_lvl == 1'b0));

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      ack_ph_d   = ack_ph_q;
      sda_oe_d   = sda_oe_q;
      busy_d     = busy_q;
      rw_d       = rw_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      tx_req_d   = 1'b0;
      if (start_ev) begin
         state_d  = ST_ADDR;
         cnt_d    = '0;
         ack_ph_d = 1'b0;
      end else if (stop_ev) begin
         state_d  = ST_IDLE;
         cnt_d    = '0;
         ack_ph_d = 1'b0;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else begin
         case (state_q)
            ST_ADDR: if (scl_rise) begin
               shift_d = {shift_q[6:0], sda_lvl};
               cnt_d   = cnt_q + 4'd1;
               if (cnt_q == 4'd7) begin
                  cnt_d    = '0;
                  ack_ph_d = 1'b0;
                  if (addr_hit) begin
                     rw_d    = sda_lvl;
                     busy_d  = 1'b1;
                     state_d = ST_ADDR_ACK;
                  end else begin
                     busy_d  = 1'b0;
                     state_d = ST_WAIT_STOP;
                  end
               end
            end
            // ack_ph splits the ACK slot: first fall drives ACK, second fall leaves it.
            ST_ADDR_ACK: if (tx_req_q) begin
               shift_d = tx_data;
            end else if (scl_fall) begin
               if (!ack_ph_q) begin
                  sda_oe_d = 1'b1;
                  ack_ph_d = 1'b1;
                  tx_req_d = rw_q;
               end else begin
                  ack_ph_d = 1'b0;
                  if (rw_q) begin
                     sda_oe_d = ~shift_q[7];
                     shift_d  = {shift_q[6:0], 1'b0};
                     cnt_d    = 4'd1;
                     state_d  = ST_READ;
                  end else begin
                     sda_oe_d = 1'b0;
                     cnt_d    = '0;
                     state_d  = ST_WRITE;
                  end
               end
            end
            ST_WRITE: if (scl_rise) begin
               shift_d = {shift_q[6:0], sda_lvl};
               cnt_d   = cnt_q + 4'd1;
               if (cnt_q == 4'd7) begin
                  rx_data_d  = {shift_q[6:0], sda_lvl};
                  rx_valid_d = 1'b1;
                  cnt_d      = '0;
                  ack_ph_d   = 1'b0;
                  state_d    = ST_WRITE_ACK;
               end
            end
            ST_WRITE_ACK: if (scl_fall) begin
               sda_oe_d = ~ack_ph_q;
               ack_ph_d = ~ack_ph_q;
               if (ack_ph_q) state_d = ST_WRITE;
            end
            // Byte fetched after a master ACK lands here one clk after tx_req.
            ST_READ: if (tx_req_q) begin
               sda_oe_d = ~tx_data[7];
               shift_d  = {tx_data[6:0], 1'b0};
            end else if (scl_fall) begin
               if (cnt_q == 4'd8) begin
                  sda_oe_d = 1'b0;
                  cnt_d    = '0;
                  ack_ph_d = 1'b0;
                  state_d  = ST_READ_ACK;
               end else begin
                  sda_oe_d = ~shift_q[7];
                  shift_d  = {shift_q[6:0], 1'b0};
                  cnt_d    = cnt_q + 4'd1;
               end
            end
            ST_READ_ACK: if (ack_ph_q) begin
               if (scl_fall) begin
                  tx_req_d = 1'b1;
                  ack_ph_d = 1'b0;
                  cnt_d    = 4'd1;
                  state_d  = ST_READ;
               end
            end else if (scl_rise) begin
               if (sda_lvl == I2C_ACK) begin
                  ack_ph_d = 1'b1;
               end else begin
                  busy_d  = 1'b0;
                  state_d = ST_WAIT_STOP;
               end
            end
            ST_WAIT_STOP: sda_oe_d = 1'b0;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         shift_q    <= '0;
         ack_ph_q   <= 1'b0;
         sda_oe_q   <= 1'b0;
         busy_q     <= 1'b0;
         rw_q       <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         tx_req_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         ack_ph_q   <= ack_ph_d;
         sda_oe_q   <= sda_oe_d;
         busy_q     <= busy_d;
         rw_q       <= rw_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         tx_req_q   <= tx_req_d;
      end
   end

   assign sda_oe   = sda_oe_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign tx_req   = tx_req_q;
   assign busy     = busy_q;
   assign rw       = rw_q;
   assign state_o  = state_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bus-level bench: bench acts as I2C master with open-drain SDA and a transaction-level reference.
module tb_i2c_target;

   localparam int Q = 80;  // quarter SCL period in ns (8 clk)

`ifdef I2C_TARGET_GENCALL_EN
   localparam bit GC = 1'b1;
`else
   localparam bit GC = 1'b0;
`endif

   logic       clk = 1'b0, reset = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       sda_oe, rx_valid, tx_req, busy, rw, sda_bus;
   logic [7:0] rx_data;
   logic [2:0] state_o;

   assign sda_bus = sda_m & ~sda_oe;

   i2c_target dut (
      .clk(clk), .reset(reset), .scl_in(scl_m), .sda_in(sda_bus),
      .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_req(tx_req), .busy(busy), .rw(rw),
      .state_o(state_o)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int rxv_cnt = 0, txr_cnt = 0, both_cnt = 0;
   logic oe_seen = 1'b0;
   logic [7:0] rx_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rx_valid) begin
         rxv_cnt++;
         rx_q.push_back(rx_data);
      end
      if (tx_req) txr_cnt++;
      if (rx_valid && tx_req) both_cnt++;
      if (sda_oe) oe_seen = 1'b1;
   end

   function automatic bit exp_hit(input logic [6:0] a, input logic r);
      return (a == 7'h47) || (GC && a == 7'h00 && !r);
   endfunction

   task automatic clr_mon();
      rxv_cnt = 0; txr_cnt = 0; oe_seen = 1'b0; rx_q.delete();
   endtask

   task automatic bus_start();
      sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #Q;
   endtask

   task automatic bit_xfer(input logic b, output logic seen);
      sda_m = b; #Q; scl_m = 1'b1; #Q; seen = sda_bus; #Q; scl_m = 1'b0; #Q;
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
      bit_xfer(1'b1, ack);
   endtask

   task automatic recv_byte(input logic mack, input logic [7:0] next_tx, output logic [7:0] b);
      logic s;
      for (int i = 7; i >= 0; i--) bit_xfer(1'b1, b[i]);
      tx_data = next_tx;
      bit_xfer(mack, s);
   endtask

   // One full transaction checked against the expected ACKs, bytes and strobes.
   task automatic run_txn(input logic [6:0] a, input logic r, input int n, input logic [7:0] d0);
      logic [7:0] d[4];
      logic [7:0] got;
      logic       ack, hit;
      hit  = exp_hit(a, r);
      d[0] = d0;
      for (int i = 1; i < 4; i++) d[i] = 8'($urandom_range(0, 255));
      clr_mon();
      tx_data = d[0];
      bus_start();
      send_byte({a, r}, ack);
      check("addr_ack", ack, hit ? 0 : 1);
      check("addr_state", state_o, !hit ? 7 : (r ? 5 : 3));
      if (!r) begin
         for (int i = 0; i < n; i++) begin
            send_byte(d[i], ack);
            check("data_ack", ack, hit ? 0 : 1);
         end
         check("rx_count", rxv_cnt, hit ? n : 0);
         if (hit)
            for (int i = 0; i < n && i < rx_q.size(); i++) check("rx_byte", rx_q[i], d[i]);
      end else begin
         for (int i = 0; i < n; i++) begin
            recv_byte((i == n - 1), d[i+1], got);
            check("rd_byte", got, hit ? d[i] : 8'hFF);
         end
         check("tx_req_count", txr_cnt, hit ? n : 0);
         check("rd_end_state", state_o, 7);
      end
      check("busy_before_stop", busy, (hit && !r) ? 1 : 0);
      bus_stop();
      check("busy_after_stop", busy, 0);
      check("idle_after_stop", state_o, 0);
   endtask

   initial begin
      logic ack, s;
      logic [7:0] got;
      #30;
      check("rst_oe", sda_oe, 0);
      check("rst_outs", {rx_data, rx_valid, tx_req, busy, rw, state_o}, 0);
      reset = 1'b1;
      #(2*Q);

      // Directed write 0x47 / 0xB4
      clr_mon();
      bus_start();
      send_byte({7'h47, 1'b0}, ack);
      check("wr_addr_ack", ack, 0);
      send_byte(8'hB4, ack);
      check("wr_data_ack", ack, 0);
      check("wr_busy", busy, 1);
      check("wr_rx_count", rxv_cnt, 1);
      check("wr_rx_data", rx_data, 8'hB4);
      bus_stop();
      check("wr_busy_stop", busy, 0);
      check("wr_state_stop", state_o, 0);

      // Address mismatch
      clr_mon();
      bus_start();
      send_byte({7'h73, 1'b0}, ack);
      check("mm_addr_nack", ack, 1);
      check("mm_state", state_o, 7);
      send_byte(8'h55, ack);
      check("mm_data_nack", ack, 1);
      check("mm_state2", state_o, 7);
      check("mm_oe_never", oe_seen, 0);
      check("mm_rx_count", rxv_cnt, 0);
      bus_stop();
      check("mm_state_stop", state_o, 0);

      // Directed read 0xC9 with master NACK
      clr_mon();
      tx_data = 8'hC9;
      bus_start();
      send_byte({7'h47, 1'b1}, ack);
      check("rd_addr_ack", ack, 0);
      check("rd_rw", rw, 1);
      recv_byte(1'b1, 8'h00, got);
      check("rd_bits", got, 8'hC9);
      check("rd_tx_req", txr_cnt, 1);
      check("rd_wait_stop", state_o, 7);
      check("rd_busy_nack", busy, 0);
      bus_stop();

      // Repeated START mid-write, then reset while ACKing the new address
      clr_mon();
      bus_start();
      send_byte({7'h47, 1'b0}, ack);
      for (int i = 0; i < 4; i++) bit_xfer(i[0], s);
      bus_start();
      check("rs_state_addr", state_o, 1);
      for (int i = 7; i >= 0; i--) begin
         logic [7:0] ab;
         ab = {7'h47, 1'b1};
         bit_xfer(ab[i], s);
      end
      check("rs_state_ack", state_o, 2);
      check("rs_rw", rw, 1);
      check("rs_no_rx", rxv_cnt, 0);
      check("rs_oe_ack", sda_oe, 1);
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      check("arst_oe", sda_oe, 0);
      check("arst_outs", {rx_data, rx_valid, tx_req, busy, rw, state_o}, 0);
      scl_m = 1'b1; sda_m = 1'b1;
      #50;
      reset = 1'b1;
      #(2*Q);

      // General call write
      run_txn(7'h00, 1'b0, 1, 8'h06);

      // Randomized transactions
      for (int t = 0; t < 10; t++) begin
         logic [6:0] a;
         int sel;
         sel = int'($urandom_range(0, 3));
         a = (sel < 2) ? 7'h47 : (sel == 2) ? 7'h00 : 7'($urandom_range(1, 127));
         run_txn(a, 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)), 8'($urandom_range(0, 255)));
      end

      check("never_both_strobes", both_cnt, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
